paddle_array: RTL and testbench

- Parametrised N-paddle controller for the pong datapath, driven by clk_1ms.
- Per paddle: held buttons move it with accelerating speed, or an auto mode tracks the ball's y coordinate.
- Outputs paddle centre coordinates and direction to collision logic, and per-pixel hit flags plus colour to the VGA renderer.
- Paddle i sits on the left wall if i is even and the right wall if i is odd; pair k=i/2 is inset by k*LANE_STEP.

---
 rtl/pong_pkg.sv | 32 +++
 rtl/paddle_array_if.sv | 29 ++
 rtl/paddle_motion.sv | 104 ++++++++++
 rtl/paddle_array.sv | 89 ++++++++
 tb/tb_paddle_array.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared pong constants: screen geometry, direction codes, colours and paddle x placement.
// Pure declarations; no timing or flow-control behaviour.
package pong_pkg;

    localparam int COORD_W  = 10;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [COORD_W-1:0] coord_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    localparam logic [11:0] RGB_LEFT  = 12'hF00;
    localparam logic [11:0] RGB_RIGHT = 12'h00F;
    localparam logic [11:0] RGB_NONE  = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE = DIR_IDLE,
        ST_UP   = DIR_UP,
        ST_DN   = DIR_DN
    } paddle_state_e;

    // Even paddles hug the left wall, odd ones mirror them on the right.
    function automatic int paddle_xc(input int idx, input int margin, input int w, input int step);
        int off;
        off = margin + w / 2 + (idx / 2) * step;
        return (idx % 2 == 0) ? off : H_ACTIVE - off;
    endfunction

endpackage

// File: rtl/paddle_array_if.sv
// Button/ball/raster inputs and paddle geometry/pixel outputs of the paddle array.
// Plain wires; no handshake, the array never stalls.
interface paddle_array_if #(
    parameter int NUM_PADDLES = 2
) ();

    logic [NUM_PADDLES-1:0]    btn_up_n;
    logic [NUM_PADDLES-1:0]    btn_dn_n;
    logic [NUM_PADDLES-1:0]    auto_en;
    logic [9:0]                ball_y;
    logic [9:0]                x;
    logic [9:0]                y;
    logic [10*NUM_PADDLES-1:0] x_paddle;
    logic [10*NUM_PADDLES-1:0] y_paddle;
    logic [2*NUM_PADDLES-1:0]  paddle_dir;
    logic [NUM_PADDLES-1:0]    paddle_on;
    logic [11:0]               pixel_rgb;

    modport master (
        output btn_up_n, btn_dn_n, auto_en, ball_y, x, y,
        input  x_paddle, y_paddle, paddle_dir, paddle_on, pixel_rgb
    );

    modport slave (
        input  btn_up_n, btn_dn_n, auto_en, ball_y, x, y,
        output x_paddle, y_paddle, paddle_dir, paddle_on, pixel_rgb
    );

endinterface

// File: rtl/paddle_motion.sv
// One paddle: manual/auto request decode, accelerating speed, clamped y register.
// Position and direction update one clk_1ms tick after the request; never stalls.
module paddle_motion
    import pong_pkg::*;
#(
    parameter int PADDLE_H    = 80,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int AUTO_SPEED  = 2,
    parameter int DEADBAND    = 4
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       btn_up_n_i,
    input  logic       btn_dn_n_i,
    input  logic       auto_en_i,
    input  logic [9:0] ball_y_i,
    output logic [9:0] y_o,
    output logic [1:0] dir_o
);

    localparam int HOLD_SAT = MAX_SPEED * ACCEL_TICKS;
    localparam int HOLD_W   = $clog2(HOLD_SAT + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_SAT);
    localparam logic signed [10:0] YMIN_S  = 11'(PADDLE_H / 2);
    localparam logic signed [10:0] YMAX_S  = 11'(V_ACTIVE - PADDLE_H / 2);
    localparam logic signed [10:0] DB_S    = 11'(DEADBAND);
    localparam coord_t             Y_RST   = coord_t'(V_ACTIVE / 2);

    paddle_state_e      state_q, state_d;
    coord_t             y_q, y_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [HOLD_W-1:0]  hold_eff;
    logic signed [10:0] y_s, ball_s, step_s, cand_s;
    int                 spd;

    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            y_q     <= Y_RST;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = ST_IDLE;
        y_d      = y_q;
        hold_d   = '0;
        hold_eff = '0;
        spd      = 1;
        step_s   = '0;
        cand_s   = '0;
        y_s      = {1'b0, y_q};
        ball_s   = {1'b0, ball_y_i};

        if (auto_en_i) begin
            if (ball_s + DB_S < y_s) begin
                state_d = ST_UP;
            end else if (ball_s > y_s + DB_S) begin
                state_d = ST_DN;
            end
            spd = AUTO_SPEED;
        end else begin
            if (!btn_up_n_i && btn_dn_n_i) begin
                state_d = ST_UP;
            end else if (btn_up_n_i && !btn_dn_n_i) begin
                state_d = ST_DN;
            end
            // Only a continued direction keeps its accumulated hold time.
            if (state_d == state_q) begin
                hold_eff = hold_q;
            end
            spd = 1 + int'(hold_eff) / ACCEL_TICKS;
            if (spd > MAX_SPEED) begin
                spd = MAX_SPEED;
            end
            if (state_d != ST_IDLE) begin
                hold_d = (hold_eff >= HOLD_MAX) ? HOLD_MAX : hold_eff + 1'b1;
            end
        end

        step_s = 11'(spd);
        case (state_d)
            ST_UP: begin
                cand_s = y_s - step_s;
                y_d    = (cand_s < YMIN_S) ? coord_t'(YMIN_S) : coord_t'(cand_s);
            end
            ST_DN: begin
                cand_s = y_s + step_s;
                y_d    = (cand_s > YMAX_S) ? coord_t'(YMAX_S) : coord_t'(cand_s);
            end
            default: y_d = y_q;
        endcase
    end

    assign y_o   = y_q;
    assign dir_o = state_q;

endmodule

// File: rtl/paddle_array.sv
// N paddles for the pong datapath: per-paddle motion plus fixed x placement, pixel hit test and colour mux.
// Geometry is registered (one tick latency); hit/colour are combinational from it; never stalls.
module paddle_array
    import pong_pkg::*;
#(
    parameter int          NUM_PADDLES = 2,
    parameter int          PADDLE_W    = 16,
    parameter int          PADDLE_H    = 80,
    parameter int          EDGE_MARGIN = 20,
    parameter int          LANE_STEP   = 64,
    parameter int          MAX_SPEED   = 4,
    parameter int          ACCEL_TICKS = 8,
    parameter int          AUTO_SPEED  = 2,
    parameter int          DEADBAND    = 4,
    parameter logic [11:0] COLOR_LEFT  = RGB_LEFT,
    parameter logic [11:0] COLOR_RIGHT = RGB_RIGHT
) (
    input  logic          clk_1ms,
    input  logic          reset,
    paddle_array_if.slave bus
);

    localparam logic signed [10:0] HW_S = 11'(PADDLE_W / 2);
    localparam logic signed [10:0] HH_S = 11'(PADDLE_H / 2);

    coord_t                 y_arr   [NUM_PADDLES];
    logic [1:0]             dir_arr [NUM_PADDLES];
    logic [NUM_PADDLES-1:0] hit;
    logic [11:0]            rgb;
    logic signed [10:0]     px_s, py_s;

    for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_paddle
        paddle_motion #(
            .PADDLE_H    (PADDLE_H),
            .MAX_SPEED   (MAX_SPEED),
            .ACCEL_TICKS (ACCEL_TICKS),
            .AUTO_SPEED  (AUTO_SPEED),
            .DEADBAND    (DEADBAND)
        ) u_motion (
            .clk_1ms    (clk_1ms),
            .reset      (reset),
            .btn_up_n_i (bus.btn_up_n[g]),
            .btn_dn_n_i (bus.btn_dn_n[g]),
            .auto_en_i  (bus.auto_en[g]),
            .ball_y_i   (bus.ball_y),
            .y_o        (y_arr[g]),
            .dir_o      (dir_arr[g])
        );
    end

    // Both ranges are half-open so each paddle covers exactly PADDLE_W x PADDLE_H pixels.
    always_comb begin
        px_s = {1'b0, bus.x};
        py_s = {1'b0, bus.y};
        hit  = '0;
        for (int i = 0; i < NUM_PADDLES; i++) begin
            logic signed [10:0] xc_s;
            logic signed [10:0] yc_s;
            xc_s   = 11'(paddle_xc(i, EDGE_MARGIN, PADDLE_W, LANE_STEP));
            yc_s   = {1'b0, y_arr[i]};
            hit[i] = (px_s >= xc_s - HW_S) && (px_s < xc_s + HW_S) &&
                     (py_s >= yc_s - HH_S) && (py_s < yc_s + HH_S);
        end
    end

    // Walking down from the top index leaves the lowest active paddle's colour.
    always_comb begin
        rgb = RGB_NONE;
        for (int i = NUM_PADDLES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                rgb = (i % 2 == 0) ? COLOR_LEFT : COLOR_RIGHT;
            end
        end
    end

    always_comb begin
        bus.x_paddle   = '0;
        bus.y_paddle   = '0;
        bus.paddle_dir = '0;
        for (int i = 0; i < NUM_PADDLES; i++) begin
            bus.x_paddle[10*i +: 10]  = coord_t'(paddle_xc(i, EDGE_MARGIN, PADDLE_W, LANE_STEP));
            bus.y_paddle[10*i +: 10]  = y_arr[i];
            bus.paddle_dir[2*i +: 2]  = dir_arr[i];
        end
        bus.paddle_on = hit;
        bus.pixel_rgb = rgb;
    end

endmodule

// File: tb/tb_paddle_array.sv
module tb_paddle_array;

    logic clk_1ms;
    logic rst_n;

    logic [7:0]  up_n [2];
    logic [7:0]  dn_n [2];
    logic [7:0]  aut  [2];
    logic [9:0]  ball, px, py;

    logic [79:0] xo   [2];
    logic [79:0] yo   [2];
    logic [15:0] diro [2];
    logic [7:0]  ono  [2];
    logic [11:0] rgbo [2];

    int checks = 0;
    int errors = 0;

    int my   [2][8];
    int mdir [2][8];
    int mrun [2][8];

    paddle_array_if #(.NUM_PADDLES(2)) bus2 ();
    paddle_array_if #(.NUM_PADDLES(4)) bus4 ();

    paddle_array #(.NUM_PADDLES(2)) dut (
        .clk_1ms (clk_1ms),
        .reset   (rst_n),
        .bus     (bus2)
    );

    // All four paddles stacked at x=320 so every paddle overlaps every other.
    paddle_array #(.NUM_PADDLES(4), .LANE_STEP(0), .EDGE_MARGIN(312)) dut4 (
        .clk_1ms (clk_1ms),
        .reset   (rst_n),
        .bus     (bus4)
    );

    assign bus2.btn_up_n = up_n[0][1:0];
    assign bus2.btn_dn_n = dn_n[0][1:0];
    assign bus2.auto_en  = aut[0][1:0];
    assign bus2.ball_y   = ball;
    assign bus2.x        = px;
    assign bus2.y        = py;
    assign bus4.btn_up_n = up_n[1][3:0];
    assign bus4.btn_dn_n = dn_n[1][3:0];
    assign bus4.auto_en  = aut[1][3:0];
    assign bus4.ball_y   = ball;
    assign bus4.x        = px;
    assign bus4.y        = py;

    assign xo[0]   = 80'(bus2.x_paddle);
    assign yo[0]   = 80'(bus2.y_paddle);
    assign diro[0] = 16'(bus2.paddle_dir);
    assign ono[0]  = 8'(bus2.paddle_on);
    assign rgbo[0] = bus2.pixel_rgb;
    assign xo[1]   = 80'(bus4.x_paddle);
    assign yo[1]   = 80'(bus4.y_paddle);
    assign diro[1] = 16'(bus4.paddle_dir);
    assign ono[1]  = 8'(bus4.paddle_on);
    assign rgbo[1] = bus4.pixel_rgb;

    initial begin
        clk_1ms = 1'b0;
        forever #5 clk_1ms = ~clk_1ms;
    end

    task automatic chk(input string nm, input int k, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst=%0d idx=%0d got=%0d expected=%0d", nm, k, i, act, exp);
        end
    endtask

    function automatic int npad(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int model_xc(input int k, input int i);
        int m;
        m = (k == 0) ? 20 + 8 + (i / 2) * 64 : 312 + 8;
        return (i % 2 == 0) ? m : 640 - m;
    endfunction

    function automatic void mreset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                my[k][i]   = 240;
                mdir[k][i] = 0;
                mrun[k][i] = 0;
            end
    endfunction

    // Reference: 0 idle, 1 up, 2 down; mrun = consecutive earlier manual ticks in the same direction.
    function automatic void mstep();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < npad(k); i++) begin
                int req, spd, b;
                b = int'(ball);
                if (aut[k][i]) begin
                    req = (b + 4 < my[k][i]) ? 1 : (b > my[k][i] + 4) ? 2 : 0;
                    spd = 2;
                end else begin
                    req = (!up_n[k][i] && dn_n[k][i]) ? 1 : (up_n[k][i] && !dn_n[k][i]) ? 2 : 0;
                    spd = (req == mdir[k][i]) ? 1 + mrun[k][i] / 8 : 1;
                    if (spd > 4) spd = 4;
                end
                if (req == 1) my[k][i] = (my[k][i] - spd < 40) ? 40 : my[k][i] - spd;
                if (req == 2) my[k][i] = (my[k][i] + spd > 440) ? 440 : my[k][i] + spd;
                if (aut[k][i] || req == 0) mrun[k][i] = 0;
                else mrun[k][i] = (req == mdir[k][i]) ? mrun[k][i] + 1 : 1;
                mdir[k][i] = req;
            end
    endfunction

    task automatic compare();
        int pxi, pyi;
        pxi = int'(px);
        pyi = int'(py);
        for (int k = 0; k < 2; k++) begin
            int first;
            first = -1;
            for (int i = 0; i < npad(k); i++) begin
                int xm, hit;
                xm  = model_xc(k, i);
                hit = (pxi >= xm - 8 && pxi < xm + 8 && pyi >= my[k][i] - 40 && pyi < my[k][i] + 40) ? 1 : 0;
                chk("y_paddle", k, i, int'(yo[k][10*i +: 10]), my[k][i]);
                chk("x_paddle", k, i, int'(xo[k][10*i +: 10]), xm);
                chk("paddle_dir", k, i, int'(diro[k][2*i +: 2]), mdir[k][i]);
                chk("paddle_on", k, i, int'(ono[k][i]), hit);
                if (hit == 1 && first < 0) first = i;
            end
            chk("pixel_rgb", k, first, int'(rgbo[k]), (first < 0) ? 0 : (first % 2 == 0) ? 'hF00 : 'h00F);
        end
    endtask

    always @(negedge rst_n) mreset();

    always @(posedge clk_1ms) begin
        if (!rst_n) mreset();
        else mstep();
        #1;
        compare();
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk_1ms);
        #2;
    endtask

    function automatic int yv(input int k, input int i);
        return int'(yo[k][10*i +: 10]);
    endfunction

    function automatic int dv(input int k, input int i);
        return int'(diro[k][2*i +: 2]);
    endfunction

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            up_n[k] = '1;
            dn_n[k] = '1;
            aut[k]  = '0;
        end
        ball = 10'd240;
        px   = '0;
        py   = '0;
        mreset();
        adv(3);
        chk("rst_y_pack", 0, 0, int'(yo[0][19:0]), 240 * 1024 + 240);
        chk("rst_x_pack", 0, 0, int'(xo[0][19:0]), 612 * 1024 + 28);
        chk("rst_dir", 0, 0, int'(diro[0][3:0]), 0);

        // Hold up from reset: 1,2,3,4 px/tick in blocks of eight ticks.
        rst_n = 1'b1;
        up_n[0][0] = 1'b0;
        adv(8);  chk("acc_t8", 0, 0, yv(0, 0), 232);
        adv(8);  chk("acc_t16", 0, 0, yv(0, 0), 216);
        adv(8);  chk("acc_t24", 0, 0, yv(0, 0), 192);
        adv(8);  chk("acc_t32", 0, 0, yv(0, 0), 160);
        adv(29); chk("acc_t61", 0, 0, yv(0, 0), 44);
        adv(1);  chk("acc_t62", 0, 0, yv(0, 0), 40);
        adv(5);  chk("acc_hold", 0, 0, yv(0, 0), 40);
        chk("acc_dir", 0, 0, dv(0, 0), 1);
        up_n[0][0] = 1'b1;
        adv(1);  chk("rel_dir", 0, 0, dv(0, 0), 0);

        // Down to 100 then asynchronous reset while still held.
        dn_n[0][0] = 1'b0;
        adv(27); chk("dn_to_100", 0, 0, yv(0, 0), 100);
        rst_n = 1'b0;
        #1;
        chk("async_rst_y", 0, 0, yv(0, 0), 240);
        chk("async_rst_dir", 0, 0, dv(0, 0), 0);
        dn_n[0][0] = 1'b1;
        #3;
        rst_n = 1'b1;

        // Auto tracking on paddle 1 with its up button pressed.
        aut[0][1]  = 1'b1;
        up_n[0][1] = 1'b0;
        ball       = 10'd300;
        adv(1);  chk("auto_t1", 0, 1, yv(0, 1), 242);
        chk("auto_dir", 0, 1, dv(0, 1), 2);
        adv(27); chk("auto_t28", 0, 1, yv(0, 1), 296);
        adv(3);  chk("auto_stop", 0, 1, yv(0, 1), 296);
        chk("auto_stop_dir", 0, 1, dv(0, 1), 0);
        aut[0][1] = 1'b0;

        // Both buttons pressed: no motion.
        dn_n[0][1] = 1'b0;
        adv(3);  chk("both_y", 0, 1, yv(0, 1), 296);
        chk("both_dir", 0, 1, dv(0, 1), 0);
        up_n[0][1] = 1'b1;
        dn_n[0][1] = 1'b1;

        // Reversal at speed 3 restarts at speed 1.
        up_n[0][0] = 1'b0;
        adv(18); chk("rev_up", 0, 0, yv(0, 0), 210);
        up_n[0][0] = 1'b1;
        dn_n[0][0] = 1'b0;
        adv(1);  chk("rev_dn1", 0, 0, yv(0, 0), 211);
        adv(1);  chk("rev_dn2", 0, 0, yv(0, 0), 212);
        dn_n[0][0] = 1'b1;
        adv(1);

        // Park at 42 via auto, tap to 43, then hold up into the top clamp.
        aut[0][0] = 1'b1;
        ball      = 10'd39;
        adv(110); chk("park_42", 0, 0, yv(0, 0), 42);
        aut[0][0]  = 1'b0;
        dn_n[0][0] = 1'b0;
        adv(1);  chk("tap_43", 0, 0, yv(0, 0), 43);
        dn_n[0][0] = 1'b1;
        adv(1);
        up_n[0][0] = 1'b0;
        adv(3);  chk("clamp_top3", 0, 0, yv(0, 0), 40);
        adv(5);  chk("clamp_top8", 0, 0, yv(0, 0), 40);
        chk("clamp_top_dir", 0, 0, dv(0, 0), 1);
        up_n[0][0] = 1'b1;

        // Park at 438 via auto, then hold down into the bottom clamp.
        aut[0][0] = 1'b1;
        ball      = 10'd442;
        adv(220); chk("park_438", 0, 0, yv(0, 0), 438);
        aut[0][0]  = 1'b0;
        dn_n[0][0] = 1'b0;
        adv(8);  chk("clamp_bot", 0, 0, yv(0, 0), 440);
        chk("clamp_bot_dir", 0, 0, dv(0, 0), 2);
        dn_n[0][0] = 1'b1;

        // Raster hit tests with all paddles recentred.
        rst_n = 1'b0;
        adv(1);
        rst_n = 1'b1;
        px = 10'd20;  py = 10'd200; #1;
        chk("hit_20_200", 0, 0, int'(ono[0][0]), 1);
        chk("rgb_20_200", 0, 0, int'(rgbo[0]), 'hF00);
        px = 10'd36;  py = 10'd200; #1;
        chk("hit_36_200", 0, 0, int'(ono[0][0]), 0);
        px = 10'd28;  py = 10'd280; #1;
        chk("hit_28_280", 0, 0, int'(ono[0][0]), 0);
        px = 10'd28;  py = 10'd199; #1;
        chk("hit_28_199", 0, 0, int'(ono[0][0]), 0);
        chk("rgb_none", 0, 0, int'(rgbo[0]), 0);
        px = 10'd619; py = 10'd279; #1;
        chk("hit_619_279", 0, 1, int'(ono[0][1]), 1);
        chk("rgb_right", 0, 1, int'(rgbo[0]), 'h00F);

        // Overlap priority on the stacked four-paddle instance.
        px = 10'd320; py = 10'd240; #1;
        chk("ovl_on_all", 1, 0, int'(ono[1][3:0]), 'hF);
        chk("ovl_rgb_idx0", 1, 0, int'(rgbo[1]), 'hF00);
        up_n[1][0] = 1'b0;
        adv(30); chk("ovl_move", 1, 0, yv(1, 0), 168);
        up_n[1][0] = 1'b1;
        py = 10'd260; #1;
        chk("ovl_on_123", 1, 0, int'(ono[1][3:0]), 'hE);
        chk("ovl_rgb_idx1", 1, 1, int'(rgbo[1]), 'h00F);
        adv(1);

        // Randomised run, buttons held for several ticks on average.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < npad(k); i++) begin
                    if ($urandom_range(7) == 0) begin
                        up_n[k][i] = 1'($urandom_range(1));
                        dn_n[k][i] = 1'($urandom_range(1));
                    end
                    if ($urandom_range(63) == 0) aut[k][i] = ~aut[k][i];
                end
            if ($urandom_range(15) == 0) ball = 10'($urandom_range(479));
            case ($urandom_range(3))
                0:       px = 10'(28 + $urandom_range(24) - 12);
                1:       px = 10'(612 + $urandom_range(24) - 12);
                2:       px = 10'(320 + $urandom_range(24) - 12);
                default: px = 10'($urandom_range(639));
            endcase
            py = 10'($urandom_range(479));
            if ($urandom_range(499) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            adv(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
